// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset main controller.
// Holds the state encoding, opcode constants, ALUOp codes, mux select codes,
// the control-word struct and the per-state control decode.
package multicycle_pkg;

  // FSM state encoding, also visible on the debug port
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam int OPC_W = 6;
  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_RTYPE = 6'h00;
  localparam opcode_t OP_J     = 6'h02;
  localparam opcode_t OP_BEQ   = 6'h04;
  localparam opcode_t OP_ADDI  = 6'h08;
  localparam opcode_t OP_SLTI  = 6'h0A;
  localparam opcode_t OP_LW    = 6'h23;
  localparam opcode_t OP_SW    = 6'h2B;

  localparam logic [2:0] ALUOP_RTYPE = 3'd0;
  localparam logic [2:0] ALUOP_ADD   = 3'd1;
  localparam logic [2:0] ALUOP_SUB   = 3'd2;
  localparam logic [2:0] ALUOP_SLT   = 3'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic       ALU_SRC_A_PC = 1'b0;
  localparam logic       ALU_SRC_A_RS = 1'b1;

  localparam logic [1:0] ALU_SRC_B_RT      = 2'd0;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'd2;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'd3;

  // Moore part of the control outputs; held in a register inside the FSM
  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctl_t;

  // Opcodes that continue into EXEC (J and unknown opcodes end in DECODE)
  function automatic logic op_exec(opcode_t op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SLTI) ||
           (op == OP_LW)    || (op == OP_SW)   || (op == OP_BEQ);
  endfunction

  // Control word to present while sitting in state s with latched opcode op
  function automatic ctl_t ctl_for(state_t s, opcode_t op);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_a = ALU_SRC_A_PC;
        c.alu_src_b = ALU_SRC_B_FOUR;
        c.alu_op    = ALUOP_ADD;
      end
      DECODE: begin
        // speculative branch target into ALUOut
        c.alu_src_a = ALU_SRC_A_PC;
        c.alu_src_b = ALU_SRC_B_IMM_SH2;
        c.alu_op    = ALUOP_ADD;
      end
      EXEC: begin
        c.alu_src_a = ALU_SRC_A_RS;
        case (op)
          OP_RTYPE: begin
            c.alu_src_b = ALU_SRC_B_RT;
            c.alu_op    = ALUOP_RTYPE;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            c.alu_src_b = ALU_SRC_B_IMM;
            c.alu_op    = ALUOP_ADD;
          end
          OP_SLTI: begin
            c.alu_src_b = ALU_SRC_B_IMM;
            c.alu_op    = ALUOP_SLT;
          end
          OP_BEQ: begin
            c.alu_src_b = ALU_SRC_B_RT;
            c.alu_op    = ALUOP_SUB;
            c.pc_src    = PC_SRC_ALUOUT;
          end
          default: ;
        endcase
      end
      MEM: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = (op == OP_SW);
      end
      WB: begin
        c.reg_we     = 1'b1;
        c.reg_dst    = (op == OP_RTYPE);
        c.mem_to_reg = (op == OP_LW);
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle for the multi-cycle controller.
// Inputs: opcode_i (IR[31:26]), zero_i (ALU zero), mem_ack_i (memory done).
// Outputs: memory request/strobes, PC/IR enables, ALU mux selects, ALUOp,
// register-file strobes, illegal pulse and debug state.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
);
  logic [OP_W-1:0]    opcode_i;
  logic               zero_i;
  logic               mem_ack_i;
  logic               mem_req_o;
  logic               mem_we_o;
  logic               iord_o;
  logic               ir_we_o;
  logic               pc_we_o;
  logic [1:0]         pc_src_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [ALUOP_W-1:0] alu_op_o;
  logic               reg_we_o;
  logic               reg_dst_o;
  logic               mem_to_reg_o;
  logic               illegal_o;
  logic [2:0]         state_o;

  modport master (
    input  opcode_i, zero_i, mem_ack_i,
    output mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_we_o, reg_dst_o,
           mem_to_reg_o, illegal_o, state_o
  );

  modport slave (
    output opcode_i, zero_i, mem_ack_i,
    input  mem_req_o, mem_we_o, iord_o, ir_we_o, pc_we_o, pc_src_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, reg_we_o, reg_dst_o,
           mem_to_reg_o, illegal_o, state_o
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multi-cycle MIPS-subset CPU: FETCH/DECODE/EXEC/MEM/WB.
// Ports: clk_i, rst_i (sync, active-high), bus (multicycle_ctrl_if.master);
// with MC_CTRL_PERF_CNT_EN defined also cyc_cnt_o / instr_cnt_o [PERF_W].
// Memory request is held until mem_ack_i; an ack with no request is ignored.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int PERF_W  = 32
) (
  input logic clk_i,
  input logic rst_i,
  multicycle_ctrl_if.master bus
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt_o,
  output logic [PERF_W-1:0] instr_cnt_o
`endif
);

  state_t          state_q;
  opcode_t         op_q;     // opcode latched in DECODE, used by later states
  ctl_t            ctl_q;    // registered Moore control word
  logic [OP_W-1:0] opcode_raw;
  opcode_t         op_in;
  logic            mem_done;
  logic            fetch_done;
  logic            dec_jump;
  logic            dec_illegal;
  logic            beq_take;

  assign opcode_raw = bus.opcode_i;
  assign op_in      = opcode_t'(opcode_raw);

  // ack only counts while a request is actually outstanding
  assign mem_done    = ctl_q.mem_req && bus.mem_ack_i && !rst_i;
  assign fetch_done  = (state_q == FETCH) && mem_done;
  assign dec_jump    = (state_q == DECODE) && (op_in == OP_J) && !rst_i;
  assign dec_illegal = (state_q == DECODE) && (op_in != OP_J) &&
                       !op_exec(op_in) && !rst_i;
  assign beq_take    = (state_q == EXEC) && (op_q == OP_BEQ) &&
                       bus.zero_i && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      op_q    <= '0;
      ctl_q   <= ctl_for(FETCH, '0);
    end else begin
      case (state_q)
        FETCH: begin
          if (fetch_done) begin
            state_q <= DECODE;
            ctl_q   <= ctl_for(DECODE, op_q);
          end
        end
        DECODE: begin
          op_q <= op_in;
          if (op_exec(op_in)) begin
            state_q <= EXEC;
            ctl_q   <= ctl_for(EXEC, op_in);
          end else begin
            // J and unknown opcodes both finish here
            state_q <= FETCH;
            ctl_q   <= ctl_for(FETCH, op_in);
          end
        end
        EXEC: begin
          case (op_q)
            OP_LW, OP_SW: begin
              state_q <= MEM;
              ctl_q   <= ctl_for(MEM, op_q);
            end
            OP_BEQ: begin
              state_q <= FETCH;
              ctl_q   <= ctl_for(FETCH, op_q);
            end
            default: begin
              state_q <= WB;
              ctl_q   <= ctl_for(WB, op_q);
            end
          endcase
        end
        MEM: begin
          if (mem_done) begin
            if (op_q == OP_SW) begin
              state_q <= FETCH;
              ctl_q   <= ctl_for(FETCH, op_q);
            end else begin
              state_q <= WB;
              ctl_q   <= ctl_for(WB, op_q);
            end
          end
        end
        WB: begin
          state_q <= FETCH;
          ctl_q   <= ctl_for(FETCH, op_q);
        end
        default: begin
          state_q <= FETCH;
          ctl_q   <= ctl_for(FETCH, '0);
        end
      endcase
    end
  end

  // The control register already holds FETCH values during reset so the
  // first post-reset cycle fetches; outputs are forced low while rst_i is up.
  assign bus.mem_req_o    = !rst_i && ctl_q.mem_req;
  assign bus.mem_we_o     = !rst_i && ctl_q.mem_we;
  assign bus.iord_o       = !rst_i && ctl_q.iord;
  assign bus.alu_src_a_o  = !rst_i && ctl_q.alu_src_a;
  assign bus.alu_src_b_o  = rst_i ? 2'd0 : ctl_q.alu_src_b;
  assign bus.alu_op_o     = rst_i ? '0 : ALUOP_W'(ctl_q.alu_op);
  assign bus.reg_we_o     = !rst_i && ctl_q.reg_we;
  assign bus.reg_dst_o    = !rst_i && ctl_q.reg_dst;
  assign bus.mem_to_reg_o = !rst_i && ctl_q.mem_to_reg;
  assign bus.ir_we_o      = fetch_done;
  assign bus.pc_we_o      = fetch_done || dec_jump || beq_take;
  assign bus.pc_src_o     = rst_i    ? 2'd0 :
                            dec_jump ? PC_SRC_JUMP : ctl_q.pc_src;
  assign bus.illegal_o    = dec_illegal;
  assign bus.state_o      = state_q;

`ifdef MC_CTRL_PERF_CNT_EN
  logic instr_done;

  // true on the last cycle of an instruction (next state is FETCH)
  always_comb begin
    instr_done = 1'b0;
    case (state_q)
      DECODE:  instr_done = !op_exec(op_in);
      EXEC:    instr_done = (op_q == OP_BEQ);
      MEM:     instr_done = mem_done && (op_q == OP_SW);
      WB:      instr_done = 1'b1;
      default: instr_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cyc_cnt_o   <= '0;
      instr_cnt_o <= '0;
    end else begin
      cyc_cnt_o <= cyc_cnt_o + 1'b1;
      if (instr_done) begin
        instr_cnt_o <= instr_cnt_o + 1'b1;
      end
    end
  end
`else
  logic unused_perf_cfg;
  assign unused_perf_cfg = (PERF_W > 0);
`endif

endmodule
